hd_downsizer: RTL

Width-reducing stage that sits directly downstream of the HD pipeline/skid stage. It accepts full DATA_WIDTH words over a valid/ready handshake and emits them as RATIO = DATA_WIDTH/OUT_WIDTH narrower beats, least-significant slice first, over a second valid/ready handshake. It provides full throughput (one beat per cycle, no bubble between words) and holds its output stable under backpressure.

---
 rtl/hd_downsizer.sv | 83 ++++++++
 1 files changed

// File: rtl/hd_downsizer.sv
// Splits DATA_WIDTH words into RATIO narrower beats, LSB slice first.
// Optional last_output port enabled by defining HD_DSZ_LAST_EN.
module hd_downsizer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data_src,
  output logic                  ready_output,
  output logic                  valid_output,
  output logic [OUT_WIDTH-1:0]  data_dest,
  input  logic                  ready
`ifdef HD_DSZ_LAST_EN
  ,
  output logic                  last_output
`endif
);

  localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int BW    = $clog2(RATIO);
  localparam logic [BW-1:0] LAST = BW'(RATIO - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]           beat_q, beat_d;

  logic xfer;
  logic last_beat;
  logic accept;

  assign valid_output = (state_q == SEND);
  assign data_dest    = shreg_q[OUT_WIDTH-1:0];
  assign xfer         = valid_output && ready;
  assign last_beat    = (beat_q == LAST);

  // Combinational from ready so a new word can load on the last beat.
  assign ready_output = rst &&
                        ((state_q == IDLE) || (xfer && last_beat));
  assign accept       = valid && ready_output;

`ifdef HD_DSZ_LAST_EN
  assign last_output  = valid_output && last_beat;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    beat_d  = beat_q;
    if (xfer) begin
      shreg_d = shreg_q >> OUT_WIDTH;
      beat_d  = beat_q + BW'(1);
      if (last_beat) begin
        state_d = IDLE;
        beat_d  = '0;
      end
    end
    if (accept) begin
      shreg_d = data_src;
      beat_d  = '0;
      state_d = SEND;
    end
  end

endmodule
